// File: rtl/hx8357_bus_ctrl.sv
// ---------------------------------------------------------------------------
// hx8357_bus_ctrl
// Write-side controller for the HX8357 8080-style 16-bit parallel bus.
// Turns one-cycle cmd/data strobes from the init/command sequencer into
// CSX/DCX/WRX timing on the panel pins and pulses transmission_cmpl once per
// finished write. A one-deep pending slot holds a strobe that arrives while a
// write is in flight; back-to-back writes are burst with CSX kept low.
//
// Parameters (all 1..255):
//   CS_SETUP        cycles CSX/DCX/D are stable before WRX falls
//   WR_LOW_CYCLES   WRX low width
//   WR_HIGH_CYCLES  WRX high width after the rising edge (data hold)
//   CS_HOLD         cycles CSX stays low after the final write
//
// Ports:
//   clk                in   single clock, posedge
//   res                in   asynchronous active-high reset
//   cmd                in   strobe: data_lines is a command word (DCX=0)
//   data               in   strobe: data_lines is a parameter/pixel word (DCX=1)
//   data_lines[15:0]   in   word sampled on the strobe cycle
//   transmission_cmpl  out  one-cycle pulse per completed write
//   busy               out  write active or pending
//   proto_err          out  sticky: both strobes at once, or pending overrun
//   lcd_csx/dcx/wrx/rdx out registered panel control pins (rdx fixed high)
//   lcd_d[15:0]        out  registered panel data bus
// ---------------------------------------------------------------------------
module hx8357_bus_ctrl #(
  parameter int CS_SETUP       = 1,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int CS_HOLD        = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd,
  input  logic        data,
  input  logic [15:0] data_lines,
  output logic        transmission_cmpl,
  output logic        busy,
  output logic        proto_err,
  output logic        lcd_csx,
  output logic        lcd_dcx,
  output logic        lcd_wrx,
  output logic        lcd_rdx,
  output logic [15:0] lcd_d
);

  // Reject timing values the 8-bit down-counter cannot represent.
  if (CS_SETUP < 1 || CS_SETUP > 255) begin : g_bad_cs_setup
    $error("hx8357_bus_ctrl: CS_SETUP must be 1..255");
  end
  if (WR_LOW_CYCLES < 1 || WR_LOW_CYCLES > 255) begin : g_bad_wr_low
    $error("hx8357_bus_ctrl: WR_LOW_CYCLES must be 1..255");
  end
  if (WR_HIGH_CYCLES < 1 || WR_HIGH_CYCLES > 255) begin : g_bad_wr_high
    $error("hx8357_bus_ctrl: WR_HIGH_CYCLES must be 1..255");
  end
  if (CS_HOLD < 1 || CS_HOLD > 255) begin : g_bad_cs_hold
    $error("hx8357_bus_ctrl: CS_HOLD must be 1..255");
  end

  // The counter is loaded with N-1 and the state is left when it reads zero,
  // so each state lasts exactly N cycles.
  localparam logic [7:0] LP_SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] LP_LOW_LD   = 8'(WR_LOW_CYCLES - 1);
  localparam logic [7:0] LP_HIGH_LD  = 8'(WR_HIGH_CYCLES - 1);
  localparam logic [7:0] LP_HOLD_LD  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WR_LOW  = 3'd2,
    ST_WR_HIGH = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_pend_vld;
  logic        r_pend_dcx;
  logic [15:0] r_pend_word;
  logic        r_csx;
  logic        r_dcx;
  logic        r_wrx;
  logic        r_rdx;
  logic [15:0] r_d;
  logic        r_cmpl;
  logic        r_busy;
  logic        r_proto_err;

  logic w_one_strobe;
  logic w_both_strobe;
  logic w_cnt_done;
  logic w_start_direct;
  logic w_to_pend;
  logic w_overrun;
  logic w_pend_pop;
  logic w_pend_vld_nxt;

  assign w_one_strobe  = cmd ^ data;
  assign w_both_strobe = cmd & data;
  assign w_cnt_done    = (r_cnt == 8'd0);

  // A strobe seen in IDLE with nothing queued drives the pins directly;
  // any other accepted strobe needs the pending slot to be free.
  assign w_start_direct = w_one_strobe & (r_state == ST_IDLE) & ~r_pend_vld;
  assign w_to_pend      = w_one_strobe & ~w_start_direct & ~r_pend_vld;
  assign w_overrun      = w_one_strobe & r_pend_vld;

  // Pending leaves the slot either from IDLE (after a HOLD that saw a strobe)
  // or at the end of WR_HIGH when bursting.
  assign w_pend_pop = r_pend_vld &
                      ((r_state == ST_IDLE) |
                       ((r_state == ST_WR_HIGH) & w_cnt_done));
  assign w_pend_vld_nxt = w_to_pend | (r_pend_vld & ~w_pend_pop);

  // Pending slot: one queued word plus its DCX bit.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pend_vld  <= 1'b0;
      r_pend_dcx  <= 1'b0;
      r_pend_word <= 16'h0000;
    end else if (w_to_pend) begin
      r_pend_vld  <= 1'b1;
      r_pend_dcx  <= ~cmd;
      r_pend_word <= data_lines;
    end else if (w_pend_pop) begin
      r_pend_vld  <= 1'b0;
    end
  end

  // Sticky protocol error: simultaneous strobes or pending overrun.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_proto_err <= 1'b0;
    end else if (w_both_strobe | w_overrun) begin
      r_proto_err <= 1'b1;
    end
  end

  // Bus FSM with registered pin, completion and busy outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_csx   <= 1'b1;
      r_dcx   <= 1'b1;
      r_wrx   <= 1'b1;
      r_rdx   <= 1'b1;
      r_d     <= 16'h0000;
      r_cmpl  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cmpl <= 1'b0;
      r_rdx  <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_pend_vld) begin
            // Word queued during HOLD: CSX was high for exactly one cycle.
            r_state <= ST_SETUP;
            r_cnt   <= LP_SETUP_LD;
            r_csx   <= 1'b0;
            r_dcx   <= r_pend_dcx;
            r_d     <= r_pend_word;
            r_busy  <= 1'b1;
          end else if (w_start_direct) begin
            r_state <= ST_SETUP;
            r_cnt   <= LP_SETUP_LD;
            r_csx   <= 1'b0;
            r_dcx   <= ~cmd;
            r_d     <= data_lines;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_busy <= 1'b1;
          if (w_cnt_done) begin
            r_state <= ST_WR_LOW;
            r_cnt   <= LP_LOW_LD;
            r_wrx   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        ST_WR_LOW: begin
          r_busy <= 1'b1;
          if (w_cnt_done) begin
            r_state <= ST_WR_HIGH;
            r_cnt   <= LP_HIGH_LD;
            r_wrx   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        ST_WR_HIGH: begin
          r_busy <= 1'b1;
          if (w_cnt_done) begin
            if (r_pend_vld) begin
              // Burst: next word goes out with CSX still low; WRX is high here
              // so DCX/D may change safely.
              r_cmpl  <= 1'b1;
              r_state <= ST_SETUP;
              r_cnt   <= LP_SETUP_LD;
              r_dcx   <= r_pend_dcx;
              r_d     <= r_pend_word;
            end else begin
              r_state <= ST_HOLD;
              r_cnt   <= LP_HOLD_LD;
            end
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_state <= ST_IDLE;
            r_csx   <= 1'b1;
            r_cmpl  <= 1'b1;
            r_busy  <= w_pend_vld_nxt;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
          r_csx   <= 1'b1;
          r_wrx   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign transmission_cmpl = r_cmpl;
  assign busy              = r_busy;
  assign proto_err         = r_proto_err;
  assign lcd_csx           = r_csx;
  assign lcd_dcx           = r_dcx;
  assign lcd_wrx           = r_wrx;
  assign lcd_rdx           = r_rdx;
  assign lcd_d             = r_d;

endmodule
